// File: rtl/rotary_setting_bank.sv
// Bank of NUM_CH modulo-MODULUS settings edited by one shared quadrature encoder.
// The encoder phases are synchronised and debounced. Each A rising edge then steps the one-hot selected channel.
module rotary_setting_bank #(
    parameter int NUM_CH    = 3,
    parameter int WIDTH     = 5,
    parameter int MODULUS   = 26,
    parameter int DB_CYCLES = 4,
    parameter logic [NUM_CH*WIDTH-1:0] RESET_VALS = '0
) (
    input  logic                    i_clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    rotary_a,
    input  logic                    rotary_b,
    output logic [NUM_CH*WIDTH-1:0] values,
    output logic [NUM_CH-1:0]       change_pulse,
    output logic [NUM_CH-1:0]       dir_last,
    output logic                    update_settings
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [WIDTH:0] VAL_MAX  = (WIDTH+1)'(MODULUS - 1);

    logic [1:0]    w_raw;
    logic          r_sync1 [2];
    logic          r_sync2 [2];
    logic          r_db    [2];
    logic [CW-1:0] r_cnt   [2];

    // Index 0 is phase A, index 1 is phase B.
    assign w_raw = {rotary_b, rotary_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_phase
            always_ff @(posedge i_clock) begin
                if (reset) begin
                    r_sync1[gi] <= 1'b1;
                    r_sync2[gi] <= 1'b1;
                    r_db[gi]    <= 1'b1;
                    r_cnt[gi]   <= '0;
                end else begin
                    r_sync1[gi] <= w_raw[gi];
                    r_sync2[gi] <= r_sync1[gi];
                    if (r_sync2[gi] == r_db[gi]) begin
                        r_cnt[gi] <= '0;
                    end else if (r_cnt[gi] == CNT_LAST) begin
                        r_db[gi]  <= r_sync2[gi];
                        r_cnt[gi] <= '0;
                    end else begin
                        r_cnt[gi] <= r_cnt[gi] + CW'(1);
                    end
                end
            end
        end
    endgenerate

    logic r_a_db_d;
    logic r_step;
    logic r_step_inc;

    // A debounced A rising edge is one step. B low at that edge means an increment.
    always_ff @(posedge i_clock) begin
        if (reset) begin
            r_a_db_d   <= 1'b1;
            r_step     <= 1'b0;
            r_step_inc <= 1'b0;
        end else begin
            r_a_db_d   <= r_db[0];
            r_step     <= r_db[0] & ~r_a_db_d;
            r_step_inc <= ~r_db[1];
        end
    end

    logic w_onehot;
    logic w_apply;
    logic r_update;

    assign w_onehot = ($countones(ch_en) == 1);
    assign w_apply  = r_step && w_onehot;

    always_ff @(posedge i_clock) begin
        if (reset) begin
            r_update <= 1'b0;
        end else begin
            r_update <= w_apply;
        end
    end

    assign update_settings = r_update;

    logic [WIDTH-1:0] r_val   [NUM_CH];
    logic             r_dir   [NUM_CH];
    logic             r_pulse [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH:0] w_cur;
            logic [WIDTH:0] w_nxt;

            assign w_cur = {1'b0, r_val[gi]};
            always_comb begin
                w_nxt = w_cur;
                if (r_step_inc) begin
                    w_nxt = (w_cur == VAL_MAX) ? '0 : w_cur + 1'b1;
                end else begin
                    w_nxt = (w_cur == '0) ? VAL_MAX : w_cur - 1'b1;
                end
            end

            always_ff @(posedge i_clock) begin
                if (reset) begin
                    r_val[gi]   <= RESET_VALS[gi*WIDTH +: WIDTH];
                    r_dir[gi]   <= 1'b0;
                    r_pulse[gi] <= 1'b0;
                end else begin
                    r_pulse[gi] <= 1'b0;
                    if (w_apply && ch_en[gi]) begin
                        r_val[gi]   <= w_nxt[WIDTH-1:0];
                        r_dir[gi]   <= r_step_inc;
                        r_pulse[gi] <= 1'b1;
                    end
                end
            end

            assign values[gi*WIDTH +: WIDTH] = r_val[gi];
            assign change_pulse[gi]          = r_pulse[gi];
            assign dir_last[gi]              = r_dir[gi];
        end
    endgenerate

endmodule
